pulse_stretch: RTL and testbench
================================

// Module: pulse_stretch
// PURPOSE
//   Converts single-cycle event pulses (e.g. button-press pulses) back into
//   fixed-width level windows that slow consumers can see, such as the buzzer
//   driver, status LEDs, and display blink logic.
//   Pulses that arrive while a window is active are queued in a saturating
//   pending counter. Queued windows are replayed back-to-back, separated by a
//   minimum low gap.
// PARAMETERS
//   HOLD_CYCLES  4  clocks level_out stays high per window (>=1)
//   GAP_CYCLES   2  minimum low clocks between consecutive windows (>=1)
//   PEND_W       2  pending-counter width; max queued = 2**PEND_W-1
// PORTS
//   clk        in   1       system clock, all state on rising edge
//   rst        in   1       asynchronous, active-high reset
//   pulse_in   in   1       event pulse, sampled every rising clk edge
//   level_out  out  1       stretched output window, registered
//   busy       out  1       high in HOLD or GAP state
//   pending    out  PEND_W  number of queued windows not yet started
//   overflow   out  1       one-cycle flag: pulse dropped, queue full
// BEHAVIOUR
//   Reset:
//   - rst=1 forces IDLE immediately (async): level_out=0, busy=0, pending=0,
//     overflow=0, counters=0.
//   - Applies mid-window too; the window is truncated, not completed.
//   States: IDLE, HOLD, GAP. level_out=1 only in HOLD; busy=1 in HOLD|GAP.
//   Timing:
//   - IDLE: pulse_in=1 at edge k -> HOLD from edge k.
//   - level_out is high for clocks k..k+HOLD_CYCLES-1 (latency 1 edge).
//   - HOLD ends at edge k+HOLD_CYCLES -> GAP for GAP_CYCLES clocks.
//   - GAP end edge: if pending>0, or pulse_in=1 at that same edge -> HOLD
//     (no IDLE cycle); otherwise -> IDLE.
//   Queueing (HOLD/GAP):
//   - pulse_in=1 increments pending.
//   - At the GAP->HOLD edge the started window consumes one queued entry;
//     if pulse_in=1 at that edge as well, pending is unchanged.
//   - If pulse_in=1 at the GAP->HOLD edge and pending=0, the pulse starts
//     the window directly; pending stays 0.
//   Saturation:
//   - pulse_in=1 with pending = 2**PEND_W-1 and no consume that edge ->
//     pulse dropped, overflow=1 for exactly one clock, pending holds.
//   - pending never wraps.
//   - overflow is registered and cleared the next clock.
//   Width: hold/gap counters are sized by $clog2 of their parameter; no
//   count ever wraps; counters reload on each state entry.
// CONFIGURATION
//   PULSE_STRETCH_RETRIGGER_EN defined:
//   - pulse_in=1 in HOLD reloads the hold counter, extending the window to
//     HOLD_CYCLES clocks after that pulse; pending is not incremented.
//   - Pulses in GAP still queue normally.
//   PULSE_STRETCH_RETRIGGER_EN undefined:
//   - Pulses in HOLD queue exactly as described above (default build).
// TESTING  (HOLD_CYCLES=4, GAP_CYCLES=2, PEND_W=2 unless stated)
//   1 single pulse at edge 10 -> level_out=1 clocks 10-13; busy=1 10-15;
//     IDLE at 16; pending stays 0.
//   2 pulses at edges 0,1,2 -> pending 1 then 2; windows at 0-3, 6-9,
//     12-15 with 2 low clocks between; busy falls at edge 18.
//   3 pulses at edges 0..4 -> pending saturates at 3 by edge 3;
//     overflow=1 for one clock after edge 4; exactly 4 windows emitted.
//   4 single pulse at 0, second pulse at edge 6 (GAP end), pending=0 ->
//     second window 6-9 with no IDLE cycle; pending stays 0.
//   5 rst pulsed at clock 2 of a HOLD with pending=2 -> all outputs 0
//     without a clock edge; after release a new pulse behaves as test 1.
//   6 RETRIGGER_EN: pulses at edges 0 and 2 -> level_out=1 clocks 0-5
//     (one window); pending=0; one GAP, then IDLE.

Source files
------------

// File: rtl/pulse_stretch.sv
// pulse_stretch: turns single-cycle event pulses into fixed-width level
// windows. Pulses arriving while a window (or its trailing gap) is active are
// queued in a saturating pending counter and replayed back-to-back, each
// window separated from the next by GAP_CYCLES low clocks.
//
// Optional build macro: PULSE_STRETCH_RETRIGGER_EN
//   defined   - a pulse during HOLD restarts the hold count, extending the
//               current window instead of queueing another one.
//   undefined - pulses during HOLD queue like pulses during GAP.
module pulse_stretch #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int PEND_W      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_in,
  output logic              level_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  // Counters run 0..N-1, so $clog2(N) bits suffice; keep at least one bit.
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int GAP_W  = (GAP_CYCLES  > 1) ? $clog2(GAP_CYCLES)  : 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t             state, state_d;
  logic [HOLD_W-1:0]  hold_cnt, hold_cnt_d;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_d;
  logic [PEND_W-1:0]  pending_d;
  logic               overflow_d;
  logic               queue_full;

  assign queue_full = (pending == PEND_MAX);

  // Next-state, counter and queue decisions for the coming edge.
  always_comb begin
    // NOTE: every target gets a default before the case so no path can
    // leave one unassigned, which would otherwise infer a latch.
    state_d    = state;
    hold_cnt_d = hold_cnt;
    gap_cnt_d  = gap_cnt;
    pending_d  = pending;
    overflow_d = 1'b0;

    case (state)
      IDLE: begin
        if (pulse_in) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
        end
      end

      HOLD: begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
        if (pulse_in) begin
          // Restart the window: HOLD_CYCLES more clocks from this pulse.
          hold_cnt_d = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_d   = GAP;
          gap_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt + 1'b1;
        end
`else
        if (pulse_in) begin
          if (queue_full) overflow_d = 1'b1;
          else            pending_d  = pending + 1'b1;
        end
        if (hold_cnt == HOLD_LAST) begin
          state_d   = GAP;
          gap_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt + 1'b1;
        end
`endif
      end

      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          if (pending != '0) begin
            // Start a queued window; a simultaneous pulse takes its place.
            state_d    = HOLD;
            hold_cnt_d = '0;
            if (!pulse_in) pending_d = pending - 1'b1;
          end else if (pulse_in) begin
            state_d    = HOLD;
            hold_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt + 1'b1;
          if (pulse_in) begin
            if (queue_full) overflow_d = 1'b1;
            else            pending_d  = pending + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered outputs; reset truncates any window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      gap_cnt   <= '0;
      pending   <= '0;
      overflow  <= 1'b0;
      level_out <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above, independent of statement order.
      state     <= state_d;
      hold_cnt  <= hold_cnt_d;
      gap_cnt   <= gap_cnt_d;
      pending   <= pending_d;
      overflow  <= overflow_d;
      level_out <= (state_d == HOLD);
      busy      <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_pulse_stretch.sv
// tb_pulse_stretch: directed scenarios plus randomized pulse trains, checked
// cycle by cycle against a window-schedule model (start time, window length,
// queued count) through an expectation queue drained by a separate monitor.
module tb_pulse_stretch;

  localparam int HOLD   = 4;
  localparam int GAP    = 2;
  localparam int PEND_W = 2;
  localparam int PMAX   = (1 << PEND_W) - 1;
`ifdef PULSE_STRETCH_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  typedef struct {
    bit level;
    bit busy;
    int pend;
    bit ovf;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              pulse_in = 1'b0;
  logic              level_out;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  int tests  = 0;
  int errors = 0;
  int windows = 0;      // rising edges of level_out seen by the monitor
  logic prev_level = 1'b0;

  exp_t exp_q[$];

  // Model: a window started at cycle m_s, level high for m_len clocks,
  // followed by GAP low-but-busy clocks; m_pend windows waiting.
  int m_n, m_s, m_len, m_pend;
  bit m_started;

  pulse_stretch #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .PEND_W(PEND_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .pulse_in  (pulse_in),
    .level_out (level_out),
    .busy      (busy),
    .pending   (pending),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_s = 0; m_len = 0; m_pend = 0; m_started = 1'b0;
  endtask

  // Advance the model across one edge with pulse p; returns outputs after it.
  function automatic exp_t model_step(input bit p);
    exp_t e;
    bit   active;
    e.ovf  = 1'b0;
    active = m_started && (m_n < m_s + m_len + GAP);
    if (!active) begin
      if (m_pend > 0) begin
        m_s = m_n; m_len = HOLD; m_started = 1'b1;
        if (!p) m_pend--;
      end else if (p) begin
        m_s = m_n; m_len = HOLD; m_started = 1'b1;
      end
    end else if (p) begin
      if (RETRIG && m_n < m_s + m_len) m_len = m_n - m_s + HOLD;
      else if (m_pend < PMAX)          m_pend++;
      else                             e.ovf = 1'b1;
    end
    e.level = m_started && (m_n >= m_s) && (m_n < m_s + m_len);
    e.busy  = m_started && (m_n < m_s + m_len + GAP);
    e.pend  = m_pend;
    m_n++;
    return e;
  endfunction

  task automatic tick(input bit p);
    @(negedge clk);
    pulse_in = p;
    exp_q.push_back(model_step(p));
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) tick(1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_level"},   int'(level_out), 0);
    check({tag, "_busy"},    int'(busy),      0);
    check({tag, "_pending"}, int'(pending),   0);
    check({tag, "_ovf"},     int'(overflow),  0);
  endtask

  // Monitor: compare DUT outputs with the queued expectation after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("level_out", int'(level_out), int'(e.level));
        check("busy",      int'(busy),      int'(e.busy));
        check("pending",   int'(pending),   e.pend);
        check("overflow",  int'(overflow),  int'(e.ovf));
      end
      if (level_out === 1'b1 && prev_level !== 1'b1) windows++;
      prev_level = level_out;
    end
  end

  // Stimulus.
  initial begin
    int w0;
    int dens;
    model_reset();
    #2;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;
    idle(3);

    // Single pulse.
    w0 = windows;
    tick(1'b1);
    idle(12);
    check("single_windows", windows - w0, 1);

    // Three back-to-back pulses.
    w0 = windows;
    tick(1'b1); tick(1'b1); tick(1'b1);
    idle(24);
    check("three_windows", windows - w0, RETRIG ? 1 : 3);

    // Five pulses: saturation and one dropped pulse.
    w0 = windows;
    for (int i = 0; i < 5; i++) tick(1'b1);
    idle(36);
    check("sat_windows", windows - w0, RETRIG ? 1 : 4);

    // Second pulse exactly at the gap-end edge.
    w0 = windows;
    tick(1'b1);
    idle(HOLD + GAP - 1);
    tick(1'b1);
    idle(14);
    check("gap_end_windows", windows - w0, 2);

    // Pulses at edges 0 and 2.
    w0 = windows;
    tick(1'b1); tick(1'b0); tick(1'b1);
    idle(16);
    check("retrig_windows", windows - w0, RETRIG ? 1 : 2);

    // Async reset in the middle of a window with work queued.
    tick(1'b1); tick(1'b1); tick(1'b1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    pulse_in = 1'b0;
    rst      = 1'b0;
    model_reset();
    w0 = windows;
    idle(2);
    tick(1'b1);
    idle(12);
    check("post_rst_windows", windows - w0, 1);

    // Randomized pulse trains with varying density.
    for (int blk = 0; blk < 30; blk++) begin
      dens = $urandom_range(5, 90);
      for (int i = 0; i < 100; i++) tick($urandom_range(0, 99) < dens);
    end
    idle(40);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
